// File: rtl/imem_boot_loader.sv
// Boot loader: streams a length-prefixed little-endian word image into imem while holding the
// CPU in reset, then releases it. Define BOOT_CHECKSUM_EN to require a trailing XOR checksum byte.
module imem_boot_loader #(
  parameter int ADDR_WIDTH = 8,
  parameter int MAX_WORDS  = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic                  rx_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  cpu_reset,
  output logic                  boot_done,
  output logic                  boot_error,
  output logic [ADDR_WIDTH:0]   words_loaded
);

  localparam int CW = ADDR_WIDTH + 1;

  typedef enum logic [2:0] {
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
`ifdef BOOT_CHECKSUM_EN
    S_CHK,
`endif
    S_RELEASE,
    S_DONE,
    S_ERROR
  } state_t;

  state_t                  state_q, state_d;
  logic [7:0]              len_lo_q, len_lo_d;
  logic [CW-1:0]           n_q, n_d;
  logic [1:0]              byte_cnt_q, byte_cnt_d;
  logic [23:0]             asm_q, asm_d;
  logic                    imem_we_q, imem_we_d;
  logic [ADDR_WIDTH-1:0]   imem_addr_q, imem_addr_d;
  logic [31:0]             imem_wdata_q, imem_wdata_d;
  logic [CW-1:0]           words_q, words_d;
`ifdef BOOT_CHECKSUM_EN
  logic [7:0]              chk_q, chk_d;
`endif

  logic                    xfer;
  logic [15:0]             len_full;
  state_t                  after_data;

`ifdef BOOT_CHECKSUM_EN
  assign after_data = S_CHK;
`else
  assign after_data = S_RELEASE;
`endif

  // Ready is purely state-based, but forced low while reset is held.
  always_comb begin
    rx_ready = 1'b0;
    case (state_q)
      S_LEN_LO, S_LEN_HI, S_DATA: rx_ready = ~reset;
`ifdef BOOT_CHECKSUM_EN
      S_CHK:                      rx_ready = ~reset;
`endif
      default:                    rx_ready = 1'b0;
    endcase
  end

  assign xfer     = rx_valid & rx_ready;
  assign len_full = {rx_data, len_lo_q};

  always_comb begin
    state_d      = state_q;
    len_lo_d     = len_lo_q;
    n_d          = n_q;
    byte_cnt_d   = byte_cnt_q;
    asm_d        = asm_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    words_d      = words_q;
`ifdef BOOT_CHECKSUM_EN
    chk_d        = chk_q;
`endif
    case (state_q)
      S_LEN_LO: begin
        if (xfer) begin
          len_lo_d = rx_data;
          state_d  = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        if (xfer) begin
          if (len_full > 16'(MAX_WORDS)) begin
            state_d = S_ERROR;
          end else begin
            n_d     = CW'(len_full);
            state_d = (len_full == 16'd0) ? after_data : S_DATA;
          end
        end
      end
      S_DATA: begin
        if (xfer) begin
          // Shift right so that after three bytes byte 0 sits in [7:0].
          asm_d      = {rx_data, asm_q[23:8]};
          byte_cnt_d = byte_cnt_q + 2'd1;
`ifdef BOOT_CHECKSUM_EN
          chk_d      = chk_q ^ rx_data;
`endif
          if (byte_cnt_q == 2'd3) begin
            imem_we_d    = 1'b1;
            imem_addr_d  = words_q[ADDR_WIDTH-1:0];
            imem_wdata_d = {rx_data, asm_q};
            words_d      = words_q + CW'(1);
            if (words_q + CW'(1) == n_q) state_d = after_data;
          end
        end
      end
`ifdef BOOT_CHECKSUM_EN
      S_CHK: begin
        if (xfer) state_d = (rx_data == chk_q) ? S_RELEASE : S_ERROR;
      end
`endif
      // One cycle so the final imem write completes before the CPU leaves reset.
      S_RELEASE: state_d = S_DONE;
      default:   state_d = state_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_LEN_LO;
      len_lo_q     <= '0;
      n_q          <= '0;
      byte_cnt_q   <= '0;
      asm_q        <= '0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      words_q      <= '0;
`ifdef BOOT_CHECKSUM_EN
      chk_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      len_lo_q     <= len_lo_d;
      n_q          <= n_d;
      byte_cnt_q   <= byte_cnt_d;
      asm_q        <= asm_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      words_q      <= words_d;
`ifdef BOOT_CHECKSUM_EN
      chk_q        <= chk_d;
`endif
    end
  end

  assign imem_we      = imem_we_q;
  assign imem_addr    = imem_addr_q;
  assign imem_wdata   = imem_wdata_q;
  assign words_loaded = words_q;
  assign cpu_reset    = (state_q != S_DONE);
  assign boot_done    = (state_q == S_DONE);
  assign boot_error   = (state_q == S_ERROR);

endmodule

// File: tb/tb_imem_boot_loader.sv
// Randomized bench for imem_boot_loader: a word-level model predicts the imem writes, final
// status and release latency of each byte stream.
module tb_imem_boot_loader;
  localparam int AW = 8;
  localparam int MW = 256;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          rx_valid = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          cpu_reset;
  logic          boot_done;
  logic          boot_error;
  logic [AW:0]   words_loaded;

  imem_boot_loader #(.ADDR_WIDTH(AW), .MAX_WORDS(MW)) dut (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_reset(cpu_reset), .boot_done(boot_done), .boot_error(boot_error),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            c;
    logic [AW-1:0] a;
    logic [31:0]   d;
  } wr_t;

  wr_t         wr_q[$];
  int          fall_cyc = -1;
  int          n_vec = 0;
  int          n_miss = 0;
  logic [7:0]  stim[$];
  logic [31:0] exp_words[$];

  always @(negedge clk) begin
    if (!reset) begin
      if (imem_we) wr_q.push_back('{cyc, imem_addr, imem_wdata});
      if (!cpu_reset && fall_cyc < 0) fall_cyc = cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // now=1 asserts reset in the current cycle instead of waiting for the next one.
  task automatic do_reset(input bit now);
    if (!now) @(negedge clk);
    #2 reset = 1'b1;
    rx_valid = 1'b0;
    #1;
    check("rst_ready", rx_ready, 0);
    check("rst_we", imem_we, 0);
    check("rst_addr", imem_addr, 0);
    check("rst_wdata", imem_wdata, 0);
    check("rst_cpu", cpu_reset, 1);
    check("rst_done", boot_done, 0);
    check("rst_err", boot_error, 0);
    check("rst_words", words_loaded, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    wr_q.delete();
    fall_cyc = -1;
    #1 check("post_rst_ready", rx_ready, 1);
    @(negedge clk);
  endtask

  // Called at a falling edge; returns at the falling edge after the byte transferred.
  task automatic send_byte(input logic [7:0] b, input int gap, output int xc);
    int n;
    while (int'($urandom_range(99)) < gap) begin
      rx_valid = 1'b0;
      @(negedge clk);
    end
    rx_valid = 1'b1;
    rx_data  = b;
    n = 0;
    while (!rx_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("ready", rx_ready, 1);
    xc = cyc;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic build_stream(input bit chk_bad);
    int         n;
    logic [7:0] x;
    n = exp_words.size();
    x = 8'h00;
    stim.delete();
    stim.push_back(8'(n));
    stim.push_back(8'(n >> 8));
    foreach (exp_words[i]) begin
      for (int k = 0; k < 4; k++) begin
        stim.push_back(exp_words[i][8*k +: 8]);
        x ^= exp_words[i][8*k +: 8];
      end
    end
`ifdef BOOT_CHECKSUM_EN
    stim.push_back(chk_bad ? (x ^ 8'h01) : x);
`else
    if (chk_bad) $display("note: checksum corruption ignored without BOOT_CHECKSUM_EN");
`endif
  endtask

  task automatic run_case(input string name, input int gap, input bit chk_bad);
    int n, nsend, n_exp, xc, last_xc, last_data_xc, miss0;
    bit len_err, exp_err;
    n            = int'({stim[1], stim[0]});
    len_err      = (n > MW);
    exp_err      = len_err || chk_bad;
    nsend        = len_err ? 2 : stim.size();
    n_exp        = len_err ? 0 : n;
    last_xc      = -1;
    last_data_xc = -1;
    miss0        = n_miss;
    for (int i = 0; i < nsend; i++) begin
      send_byte(stim[i], gap, xc);
      if (i == 2 + 4 * n - 1) last_data_xc = xc;
      last_xc = xc;
    end
    repeat (4) @(negedge clk);
    check({name, ":nwr"}, wr_q.size(), n_exp);
    for (int i = 0; i < wr_q.size() && i < n_exp; i++) begin
      check({name, ":addr"}, wr_q[i].a, i);
      check({name, ":data"}, wr_q[i].d, exp_words[i]);
    end
    if (n_exp > 0 && wr_q.size() >= n_exp)
      check({name, ":wr_lat"}, wr_q[n_exp-1].c, last_data_xc + 1);
    check({name, ":words"}, words_loaded, n_exp);
    check({name, ":done"}, boot_done, !exp_err);
    check({name, ":err"}, boot_error, exp_err);
    check({name, ":cpu_rst"}, cpu_reset, exp_err);
    check({name, ":ready_end"}, rx_ready, 0);
    check({name, ":rel_cyc"}, fall_cyc, exp_err ? -1 : last_xc + 2);
    $display("case %-8s N=%0d gap=%0d%% writes=%0d done=%0b err=%0b new_miscompares=%0d",
             name, n, gap, wr_q.size(), boot_done, boot_error, n_miss - miss0);
  endtask

  task automatic load_test1();
    exp_words.delete();
    exp_words.push_back(32'h20080005);
    exp_words.push_back(32'h2009000A);
    build_stream(1'b0);
  endtask

  initial begin
    int xc;
    int n;

    do_reset(1'b0);
    load_test1();
    run_case("t1", 0, 1'b0);

    do_reset(1'b0);
    load_test1();
    run_case("t2_gaps", 40, 1'b0);

    do_reset(1'b0);
    exp_words.delete();
    build_stream(1'b0);
    run_case("t3_n0", 0, 1'b0);

    do_reset(1'b0);
    stim.delete();
    stim.push_back(8'h01);
    stim.push_back(8'h01);
    run_case("t4_big", 0, 1'b0);

    do_reset(1'b0);
    load_test1();
    for (int i = 0; i < 6; i++) send_byte(stim[i], 0, xc);
    do_reset(1'b1);
    run_case("t5", 0, 1'b0);

    for (int r = 0; r < 6; r++) begin
      do_reset(1'b0);
      exp_words.delete();
      n = $urandom_range(1, 12);
      for (int i = 0; i < n; i++) exp_words.push_back($urandom());
      build_stream(1'b0);
      run_case("rand", 30, 1'b0);
    end

    do_reset(1'b0);
    exp_words.delete();
    for (int i = 0; i < MW; i++) exp_words.push_back($urandom());
    build_stream(1'b0);
    run_case("max", 10, 1'b0);

`ifdef BOOT_CHECKSUM_EN
    do_reset(1'b0);
    load_test1();
    build_stream(1'b1);
    run_case("t6_bad", 0, 1'b1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
